// File: rtl/pll_loop_ctrl.sv
// Acquisition/lock sequencer for the digital PLL: NCO clear, loop-gain scheduling, lock hysteresis.
// Optional acquisition timeout with a FAULT state is enabled by defining PLL_CTRL_TIMEOUT_EN.
module pll_loop_ctrl #(
  parameter int ERR_W      = 8,
  parameter int LOCK_THR   = 8,
  parameter int ACQ_CNT    = 32,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic             i_err_valid,
  input  logic [ERR_W-1:0] i_err,
  output logic             o_nco_clear,
  output logic [1:0]       o_gain_sel,
  output logic             o_gain_update,
  output logic             o_locked,
  output logic             o_timeout,
  output logic [2:0]       o_state
);

  localparam int MAX_A = (ACQ_CNT > LOCK_CNT) ? ACQ_CNT : LOCK_CNT;
  localparam int MAX_B = (UNLOCK_CNT > TIMEOUT) ? UNLOCK_CNT : TIMEOUT;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ACQ_LAST    = CNT_W'(ACQ_CNT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CNT - 1);
  localparam logic [CNT_W-1:0] UNLOCK_LAST = CNT_W'(UNLOCK_CNT - 1);

  localparam logic [1:0] GAIN_NARROW = 2'd0;
  localparam logic [1:0] GAIN_MEDIUM = 2'd1;
  localparam logic [1:0] GAIN_WIDE   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_ACQ    = 3'd2,
    ST_TRACK  = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  // Magnitude is one bit wider than the input so the most negative code does not wrap.
  function automatic logic [ERR_W:0] err_mag(input logic [ERR_W-1:0] e);
    logic [ERR_W:0] ext;
    ext = {e[ERR_W-1], e};
    if (e[ERR_W-1]) begin
      err_mag = (~ext) + {{ERR_W{1'b0}}, 1'b1};
    end else begin
      err_mag = ext;
    end
  endfunction

  function automatic logic [1:0] gain_of(input state_t s);
    case (s)
      ST_TRACK:  gain_of = GAIN_MEDIUM;
      ST_LOCKED: gain_of = GAIN_NARROW;
      default:   gain_of = GAIN_WIDE;
    endcase
  endfunction

  state_t           state_r, seq_nxt_s, state_nxt_s;
  logic [CNT_W-1:0] acq_cnt_r, lock_cnt_r, unlock_cnt_r;
  logic [CNT_W-1:0] acq_nxt_s, lock_nxt_s, unlock_nxt_s;
  logic             in_lock_s;
  logic             timeout_hit_s;
  logic [1:0]       gain_nxt_s;
  logic             nco_clear_r, gain_update_r, locked_r, timeout_r;
  logic [1:0]       gain_sel_r;

  assign in_lock_s = (err_mag(i_err) <= (ERR_W + 1)'(LOCK_THR));

  // Sequencer next state and counter updates for one cycle of the error stream.
  always_comb begin
    seq_nxt_s    = state_r;
    acq_nxt_s    = acq_cnt_r;
    lock_nxt_s   = lock_cnt_r;
    unlock_nxt_s = unlock_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (i_enable) begin
          seq_nxt_s = ST_CLEAR;
        end else begin
          seq_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: seq_nxt_s = ST_ACQ;
      ST_ACQ: begin
        if (!i_err_valid) begin
          seq_nxt_s = ST_ACQ;
        end else if (timeout_hit_s) begin
          seq_nxt_s = ST_FAULT;
        end else if (acq_cnt_r == ACQ_LAST) begin
          seq_nxt_s = ST_TRACK;
        end else begin
          acq_nxt_s = acq_cnt_r + CNT_ONE;
        end
      end
      ST_TRACK: begin
        // Lock completion outranks a budget expiry on the same sample.
        if (!i_err_valid) begin
          seq_nxt_s = ST_TRACK;
        end else if (in_lock_s && (lock_cnt_r == LOCK_LAST)) begin
          seq_nxt_s = ST_LOCKED;
        end else if (timeout_hit_s) begin
          seq_nxt_s = ST_FAULT;
        end else if (in_lock_s) begin
          lock_nxt_s = lock_cnt_r + CNT_ONE;
        end else begin
          lock_nxt_s = '0;
        end
      end
      ST_LOCKED: begin
        if (!i_err_valid) begin
          seq_nxt_s = ST_LOCKED;
        end else if (in_lock_s) begin
          unlock_nxt_s = '0;
        end else if (unlock_cnt_r == UNLOCK_LAST) begin
          seq_nxt_s = ST_ACQ;
        end else begin
          unlock_nxt_s = unlock_cnt_r + CNT_ONE;
        end
      end
      ST_FAULT: seq_nxt_s = ST_FAULT;
      default:  seq_nxt_s = ST_IDLE;
    endcase
  end

  assign state_nxt_s = i_enable ? seq_nxt_s : ST_IDLE;
  assign gain_nxt_s  = gain_of(state_nxt_s);

`ifdef PLL_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] BUDGET_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] budget_r, budget_nxt_s;

  assign timeout_hit_s = (budget_r == BUDGET_LAST);

  // Budget spans ACQ and TRACK, so it survives the ACQ->TRACK step and restarts on any other entry.
  always_comb begin
    if ((state_nxt_s != state_r) && (state_nxt_s != ST_TRACK)) begin
      budget_nxt_s = '0;
    end else if (i_err_valid && ((state_r == ST_ACQ) || (state_r == ST_TRACK))) begin
      budget_nxt_s = budget_r + CNT_ONE;
    end else begin
      budget_nxt_s = budget_r;
    end
  end

  // Acquisition budget register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      budget_r <= '0;
    end else begin
      budget_r <= budget_nxt_s;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
`endif

  // State register; every state entry restarts the sample counters.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_r      <= ST_IDLE;
      acq_cnt_r    <= '0;
      lock_cnt_r   <= '0;
      unlock_cnt_r <= '0;
    end else if (state_nxt_s != state_r) begin
      state_r      <= state_nxt_s;
      acq_cnt_r    <= '0;
      lock_cnt_r   <= '0;
      unlock_cnt_r <= '0;
    end else begin
      state_r      <= state_nxt_s;
      acq_cnt_r    <= acq_nxt_s;
      lock_cnt_r   <= lock_nxt_s;
      unlock_cnt_r <= unlock_nxt_s;
    end
  end

  // Registered control outputs decoded from the state being entered.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      nco_clear_r   <= 1'b0;
      gain_sel_r    <= GAIN_WIDE;
      gain_update_r <= 1'b0;
      locked_r      <= 1'b0;
      timeout_r     <= 1'b0;
    end else begin
      nco_clear_r   <= (state_nxt_s == ST_CLEAR);
      gain_sel_r    <= gain_nxt_s;
      gain_update_r <= (gain_nxt_s != gain_sel_r);
      locked_r      <= (state_nxt_s == ST_LOCKED);
      timeout_r     <= (state_nxt_s == ST_FAULT);
    end
  end

  assign o_nco_clear   = nco_clear_r;
  assign o_gain_sel    = gain_sel_r;
  assign o_gain_update = gain_update_r;
  assign o_locked      = locked_r;
  assign o_timeout     = timeout_r;
  assign o_state       = state_r;

endmodule

// File: tb/tb_pll_loop_ctrl.sv
// Scoreboard bench for pll_loop_ctrl: a driver feeds directed and random error streams into a
// behavioural model that queues expected outputs; a monitor compares them one cycle later.
`timescale 1ns/1ps
module tb_pll_loop_ctrl;
  localparam int ERR_W      = 8;
  localparam int LOCK_THR   = 8;
  localparam int ACQ_CNT    = 32;
  localparam int LOCK_CNT   = 16;
  localparam int UNLOCK_CNT = 4;
`ifdef PLL_CTRL_TIMEOUT_EN
  localparam int TIMEOUT = 64;
  localparam bit TO_EN   = 1'b1;
`else
  localparam int TIMEOUT = 1024;
  localparam bit TO_EN   = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             err_valid = 1'b0;
  logic [ERR_W-1:0] err_in = '0;
  logic             nco_clear, gain_update, locked, timeout;
  logic [1:0]       gain_sel;
  logic [2:0]       state;

  pll_loop_ctrl #(
    .ERR_W(ERR_W), .LOCK_THR(LOCK_THR), .ACQ_CNT(ACQ_CNT),
    .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_enable(enable), .i_err_valid(err_valid),
    .i_err(err_in), .o_nco_clear(nco_clear), .o_gain_sel(gain_sel),
    .o_gain_update(gain_update), .o_locked(locked), .o_timeout(timeout), .o_state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int clr;
    int gain;
    int upd;
    int lck;
    int to;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle_no = 0;

  // Model of the sequencer: mode 0..5 = idle, clear, acquire, track, locked, fault.
  int   m_mode = 0;
  int   m_acq = 0;
  int   m_good = 0;
  int   m_bad = 0;
  int   m_budget = 0;
  int   m_gain = 2;
  int   gain_tab[6] = '{2, 2, 2, 1, 0, 2};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cycle_no, got, want);
    end
  endtask

  task automatic cyc(input bit rst, input bit en, input bit v, input int e);
    exp_t x;
    int   nm;
    int   mag;
    bit   good;
    @(negedge clk);
    reset_n   = rst;
    enable    = en;
    err_valid = v;
    err_in    = e[ERR_W-1:0];
    if (!rst) begin
      m_mode = 0; m_acq = 0; m_good = 0; m_bad = 0; m_budget = 0; m_gain = 2;
      x = '{0, 0, 2, 0, 0, 0};
    end else begin
      nm   = m_mode;
      mag  = (e < 0) ? -e : e;
      good = (mag <= LOCK_THR);
      if (m_mode == 0 && en) nm = 1;
      else if (m_mode == 1) nm = 2;
      else if (m_mode == 2 && v) begin
        m_acq++;
        m_budget++;
        if (TO_EN && m_budget == TIMEOUT) nm = 5;
        else if (m_acq == ACQ_CNT) nm = 3;
      end else if (m_mode == 3 && v) begin
        m_budget++;
        m_good = good ? m_good + 1 : 0;
        if (m_good == LOCK_CNT) nm = 4;
        else if (TO_EN && m_budget == TIMEOUT) nm = 5;
      end else if (m_mode == 4 && v) begin
        m_bad = good ? 0 : m_bad + 1;
        if (m_bad == UNLOCK_CNT) nm = 2;
      end
      if (!en) nm = 0;
      if (nm != m_mode) begin
        m_acq = 0; m_good = 0; m_bad = 0;
        if (nm == 2) m_budget = 0;
      end
      x.st   = nm;
      x.clr  = (nm == 1);
      x.gain = gain_tab[nm];
      x.upd  = (gain_tab[nm] != m_gain);
      x.lck  = (nm == 4);
      x.to   = (nm == 5);
      m_gain = gain_tab[nm];
      m_mode = nm;
    end
    exp_q.push_back(x);
  endtask

  // A valid sample preceded by 0..2 invalid cycles carrying junk error values.
  task automatic sample(input bit en, input int e);
    int gaps;
    gaps = int'($urandom_range(0, 2));
    for (int g = 0; g < gaps; g++) cyc(1'b1, en, 1'b0, int'($urandom_range(0, 255)) - 128);
    cyc(1'b1, en, 1'b1, e);
  endtask

  // Monitor: compares every presented output set against the queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cycle_no++;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("state", 32'(state), e.st);
        chk("nco_clear", 32'(nco_clear), e.clr);
        chk("gain_sel", 32'(gain_sel), e.gain);
        chk("gain_update", 32'(gain_update), e.upd);
        chk("locked", 32'(locked), e.lck);
        chk("timeout", 32'(timeout), e.to);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d got=running want=finished", cycle_no);
    $fatal(1, "watchdog expired");
  end

  // Driver: directed scenarios followed by a long randomized run with enable drops and resets.
  initial begin
    int spread;
    int e;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b1, 0);
    cyc(1'b1, 1'b1, 1'b0, 0);
    cyc(1'b1, 1'b1, 1'b0, 0);
    repeat (ACQ_CNT) sample(1'b1, 100);
    repeat (15) sample(1'b1, 5);
    sample(1'b1, -9);
    repeat (16) sample(1'b1, -8);
    repeat (3) sample(1'b1, 50);
    sample(1'b1, 0);
    repeat (3) sample(1'b1, 50);
    sample(1'b1, -128);
    repeat (ACQ_CNT) sample(1'b1, int'($urandom_range(0, 255)) - 128);
    repeat (LOCK_CNT - 1) sample(1'b1, int'($urandom_range(0, 16)) - 8);
    cyc(1'b1, 1'b0, 1'b1, 3);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b1, 1'b0, 0);
    cyc(1'b1, 1'b1, 1'b0, 0);
    repeat (70) sample(1'b1, 100);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 0);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 0);
    spread = 8;
    for (int i = 0; i < 2000; i++) begin
      if (i % 64 == 0) spread = int'($urandom_range(6, 40));
      if ($urandom_range(0, 15) == 0) e = int'($urandom_range(0, 255)) - 128;
      else e = int'($urandom_range(0, 2 * spread)) - spread;
      cyc(($urandom_range(0, 499) != 0), ($urandom_range(0, 299) != 0),
          ($urandom_range(0, 2) != 0), e);
    end
    @(posedge clk);
    #2;
    chk("queue_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
